// File: rtl/mem_fifo_ctrl.sv
// FIFO controller driving a single-port memory (comb read, seq write, shared bus).
// Push-to-rd_valid latency is 2 cycles; reads and writes share the port, with priority alternating under contention.
module mem_fifo_ctrl #(
  parameter int dw = 8,
  parameter int w  = 16,
  parameter int aw = $clog2(w),
  parameter int cw = $clog2(w + 2)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [dw-1:0] wr_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [dw-1:0] rd_data,
  output logic [cw-1:0] count,
  output logic          mem_re,
  output logic          mem_we,
  output logic [aw-1:0] mem_addr,
  inout  tri   [dw-1:0] mem_data
);

  logic [aw-1:0] r_wptr;
  logic [aw-1:0] r_rptr;
  logic [cw-1:0] r_mem_count;
  logic          r_out_valid;
  logic [dw-1:0] r_rd_data;
  logic          r_prio;

  logic w_not_full;
  logic w_want_rd;
  logic w_want_wr;
  logic w_grant_rd;
  logic w_grant_wr;
  logic w_pop;

  // Requests are masked during reset so the port stays idle and the bus floats.
  assign w_not_full = (r_mem_count != cw'(w));
  assign w_want_rd  = !reset && (r_mem_count != '0) && (!r_out_valid || rd_ready);
  assign w_want_wr  = !reset && wr_valid && w_not_full;
  assign w_grant_rd = w_want_rd && (!w_want_wr || !r_prio);
  assign w_grant_wr = w_want_wr && (!w_want_rd || r_prio);
  assign w_pop      = r_out_valid && rd_ready;

  assign wr_ready = !reset && w_not_full && !(w_want_rd && !r_prio);
  assign mem_re   = w_grant_rd;
  assign mem_we   = w_grant_wr;
  assign mem_addr = w_grant_wr ? r_wptr : r_rptr;
  assign mem_data = w_grant_wr ? wr_data : {dw{1'bz}};

  assign rd_valid = r_out_valid;
  assign rd_data  = r_rd_data;
  assign count    = r_mem_count + cw'(r_out_valid);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_mem_count <= '0;
      r_out_valid <= 1'b0;
      r_rd_data   <= '0;
      r_prio      <= 1'b0;
    end else begin
      if (w_grant_wr)
        r_wptr <= (r_wptr == aw'(w - 1)) ? '0 : r_wptr + 1'b1;
      if (w_grant_rd) begin
        r_rd_data   <= mem_data;
        r_out_valid <= 1'b1;
        r_rptr      <= (r_rptr == aw'(w - 1)) ? '0 : r_rptr + 1'b1;
      end else if (w_pop) begin
        r_out_valid <= 1'b0;
      end
      if (w_grant_wr && !w_grant_rd)
        r_mem_count <= r_mem_count + 1'b1;
      else if (w_grant_rd && !w_grant_wr)
        r_mem_count <= r_mem_count - 1'b1;
      if (w_want_rd && w_want_wr)
        r_prio <= !r_prio;
    end
  end

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// Bench for mem_fifo_ctrl (w=4, dw=8) with a behavioural memory on the shared bus.
// Driver pushes expected pop words into a queue; a negedge monitor checks every pop.
module tb_mem_fifo_ctrl;
  localparam int DW = 8;
  localparam int W  = 4;
  localparam int AW = $clog2(W);
  localparam int CW = $clog2(W + 2);

  logic          clock = 1'b0;
  logic          reset;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic [CW-1:0] count;
  logic          mem_re;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  wire  [DW-1:0] mem_data;

  logic [DW-1:0] mem [W];

  always #5 clock = ~clock;

  assign mem_data = mem_re ? mem[mem_addr] : {DW{1'bz}};
  always @(posedge clock) if (mem_we) mem[mem_addr] <= mem_data;

  mem_fifo_ctrl #(.dw(DW), .w(W)) dut (
    .clock(clock), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .count(count), .mem_re(mem_re), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_data(mem_data)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q [$];
  int n_pop = 0, n_re = 0, n_we = 0, n_wrap = 0;
  logic [AW-1:0] last_waddr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every pop is compared with the oldest expected word.
  always @(negedge clock) begin
    if (!reset) begin
      n_checks++;
      if (mem_re && mem_we) begin
        n_fail++;
        $display("FAIL port_conflict: mem_re=1 mem_we=1 expected at most one at %0t", $time);
      end
      if (mem_re) n_re++;
      if (mem_we) begin
        n_we++;
        if (last_waddr == AW'(W - 1) && mem_addr == '0) n_wrap++;
        last_waddr = mem_addr;
      end
      if (rd_valid && rd_ready) begin
        n_pop++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL pop_unexpected: got 0x%0h expected no pop at %0t", rd_data, $time);
        end else begin
          logic [DW-1:0] e;
          e = exp_q.pop_front();
          if (rd_data !== e) begin
            n_fail++;
            $display("FAIL pop_data: got 0x%0h expected 0x%0h at %0t", rd_data, e, $time);
          end
        end
      end
    end
  end

  // Called just after a posedge; returns just after a posedge.
  task automatic push_word(input logic [DW-1:0] d, input int limit, output bit acc, output int stalls);
    acc = 1'b0;
    stalls = 0;
    wr_valid = 1'b1;
    wr_data = d;
    for (int c = 0; c < limit && !acc; c++) begin
      @(negedge clock);
      if (wr_ready) begin
        acc = 1'b1;
        exp_q.push_back(d);
      end else begin
        stalls++;
      end
      @(posedge clock); #1;
    end
    wr_valid = 1'b0;
  endtask

  task automatic wait_drained(input string name, input int limit);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || rd_valid) && c < limit) begin
      @(posedge clock); #1;
      c++;
    end
    chk({name, "_timeout"}, (c < limit), 1);
  endtask

  initial begin
    bit acc;
    int st, tot_st, pops0, we0;
    logic [DW-1:0] fill_words [6];
    reset = 1'b1; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;

    // Reset behaviour
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_mem_we", mem_we, 0);
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("idle_rd_valid", rd_valid, 0);
    chk("idle_wr_ready", wr_ready, 1);
    chk("idle_count", count, 0);
    chk("idle_mem_re", mem_re, 0);
    chk("idle_mem_we", mem_we, 0);

    // Single push: write, read, output valid two cycles later
    @(posedge clock); #1;
    wr_valid = 1'b1; wr_data = 8'hA5;
    @(negedge clock);
    chk("sp_wr_ready", wr_ready, 1);
    chk("sp_c0_we", mem_we, 1);
    chk("sp_c0_addr", mem_addr, 0);
    chk("sp_c0_bus", mem_data, 8'hA5);
    exp_q.push_back(8'hA5);
    @(posedge clock); #1 wr_valid = 1'b0;
    @(negedge clock);
    chk("sp_c1_re", mem_re, 1);
    chk("sp_c1_we", mem_we, 0);
    chk("sp_c1_addr", mem_addr, 0);
    chk("sp_c1_rd_valid", rd_valid, 0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("sp_c2_rd_valid", rd_valid, 1);
    chk("sp_c2_rd_data", rd_data, 8'hA5);
    chk("sp_c2_count", count, 1);
    @(posedge clock); #1 rd_ready = 1'b1;
    @(posedge clock); #1 rd_ready = 1'b0;
    @(negedge clock);
    chk("sp_after_count", count, 0);
    chk("sp_after_rd_valid", rd_valid, 0);
    chk("sp_queue", exp_q.size(), 0);

    // Fill: 5 words fit (4 in memory + output stage), one stall on first read
    @(posedge clock); #1;
    fill_words = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    tot_st = 0;
    for (int i = 0; i < 5; i++) begin
      push_word(fill_words[i], 8, acc, st);
      chk("fill_accept", acc, 1);
      tot_st += st;
    end
    chk("fill_stalls", tot_st, 1);
    push_word(fill_words[5], 6, acc, st);
    exp_q.delete(exp_q.size() - 1 + (acc ? 0 : 1)); // no-op unless the sixth word was wrongly accepted
    chk("fill_reject6", acc, 0);
    @(negedge clock);
    chk("fill_count", count, 5);
    chk("fill_wr_ready", wr_ready, 0);

    // Drain in order, no writes
    @(posedge clock); #1;
    pops0 = n_pop; we0 = n_we;
    rd_ready = 1'b1;
    wait_drained("drain", 20);
    rd_ready = 1'b0;
    @(negedge clock);
    chk("drain_pops", n_pop - pops0, 5);
    chk("drain_writes", n_we - we0, 0);
    chk("drain_count", count, 0);
    chk("drain_rd_valid", rd_valid, 0);

    // Streaming with both sides ready: pointers wrap, R/W share the port
    @(posedge clock); #1;
    n_re = 0; n_we = 0; n_wrap = 0; pops0 = n_pop;
    rd_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push_word(DW'(i), 8, acc, st);
      chk("stream_accept", acc, 1);
    end
    wait_drained("stream", 20);
    rd_ready = 1'b0;
    @(negedge clock);
    chk("stream_pops", n_pop - pops0, 10);
    chk("stream_writes", n_we, 10);
    chk("stream_reads", n_re, 10);
    chk("stream_wraps", (n_wrap >= 2), 1);

    // Mid-run reset discards held data
    @(posedge clock); #1;
    push_word(8'h11, 8, acc, st);
    push_word(8'h22, 8, acc, st);
    push_word(8'h33, 8, acc, st);
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("mid_count", count, 3);
    chk("mid_rd_valid", rd_valid, 1);
    @(posedge clock); #1 reset = 1'b1;
    exp_q.delete();
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_rd_valid", rd_valid, 0);
    @(posedge clock); #1;
    pops0 = n_pop;
    push_word(8'h7E, 8, acc, st);
    chk("mid_push_accept", acc, 1);
    rd_ready = 1'b1;
    wait_drained("mid", 10);
    rd_ready = 1'b0;
    chk("mid_pops", n_pop - pops0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
